// File: rtl/jtag_prog_mem_responder.sv
// PicoBLAZE program BRAM shared between the JTAG loader lane and the processor fetch port.
// Define JTAG_RESP_CHECKSUM_EN to build the image checksum register; otherwise checksum reads 0.
module jtag_prog_mem_responder #(
    parameter int unsigned BRAM_ADDRESS_WIDTH = 10,
    parameter int unsigned RELEASE_CYCLES     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          jtag_rst,
    input  logic                          jtag_en,
    input  logic                          jtag_we,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] jtag_addr,
    input  logic [17:0]                   jtag_din,
    output logic [17:0]                   jtag_dout,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] address,
    input  logic                          bram_enable,
    output logic [17:0]                   instruction,
    output logic                          cpu_reset,
    output logic                          load_active,
    output logic [BRAM_ADDRESS_WIDTH:0]   write_count,
    output logic [17:0]                   checksum
);
    localparam int unsigned AW    = BRAM_ADDRESS_WIDTH;
    localparam int unsigned DW    = 18;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 8;

    localparam logic [CW-1:0] SETTLE_INIT = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_ONE  = CW'(1);
    localparam logic [AW:0]   COUNT_MAX   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   COUNT_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_SETTLE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_settle_cnt;
    logic            r_cpu_reset;
    logic            r_load_active;
    logic [DW-1:0]   r_jtag_dout;
    logic [DW-1:0]   r_instruction;
    logic [AW:0]     r_write_count;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_act;
    logic            w_wr;
    logic            w_fetch;
    logic            w_start;
    logic [AW-1:0]   w_port_addr;
    logic [DW-1:0]   w_rd_data;

    // The loader wins the single port whenever it strobes, in every state.
    assign w_act       = jtag_en | jtag_rst;
    assign w_wr        = jtag_en & jtag_we & ~rst;
    assign w_fetch     = (r_state == S_RUN) & bram_enable & ~jtag_en;
    assign w_start     = (r_state == S_RUN) & w_act;
    assign w_port_addr = jtag_en ? jtag_addr : address;
    assign w_rd_data   = r_mem[w_port_addr];

    // Memory array carries no reset so a block reset never disturbs a loaded image.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[jtag_addr] <= jtag_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SETTLE;
            r_settle_cnt  <= SETTLE_INIT;
            r_cpu_reset   <= 1'b1;
            r_load_active <= 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_act) begin
                        r_state       <= S_LOAD;
                        r_cpu_reset   <= 1'b1;
                        r_load_active <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!w_act) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= SETTLE_INIT;
                    end
                end
                S_SETTLE: begin
                    if (w_act) begin
                        r_state <= S_LOAD;
                    end else if (r_settle_cnt == '0) begin
                        r_state       <= S_RUN;
                        r_cpu_reset   <= 1'b0;
                        r_load_active <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - SETTLE_ONE;
                    end
                end
                default: begin
                    r_state       <= S_SETTLE;
                    r_settle_cnt  <= SETTLE_INIT;
                    r_cpu_reset   <= 1'b1;
                    r_load_active <= 1'b1;
                end
            endcase
        end
    end

    // Write-first read data: a loader write echoes its own data back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jtag_dout   <= '0;
            r_instruction <= '0;
        end else begin
            if (jtag_en) begin
                r_jtag_dout <= jtag_we ? jtag_din : w_rd_data;
            end
            if (w_fetch) begin
                r_instruction <= w_rd_data;
            end
        end
    end

    // A fresh load from RUN restarts the count, including a write on the entry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_count <= '0;
        end else if (w_start) begin
            r_write_count <= w_wr ? COUNT_ONE : '0;
        end else if (w_wr && (r_write_count != COUNT_MAX)) begin
            r_write_count <= r_write_count + COUNT_ONE;
        end
    end

`ifdef JTAG_RESP_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= w_wr ? jtag_din : '0;
        end else if (w_wr) begin
            r_checksum <= r_checksum + jtag_din;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign jtag_dout   = r_jtag_dout;
    assign instruction = r_instruction;
    assign cpu_reset   = r_cpu_reset;
    assign load_active = r_load_active;
    assign write_count = r_write_count;

endmodule

// File: doc/jtag_prog_mem_responder.md
# jtag_prog_mem_responder

Program-memory responder for one PicoBLAZE instance. It terminates one lane of the JTAG loader's BRAM access bus (`jtag_en`/`jtag_we`/`jtag_addr`/`jtag_din`/`jtag_dout`/`jtag_rst`) and owns the instruction BRAM shared between the loader and the processor. The block arbitrates the single memory port, holds the processor in reset while a load is in progress, and releases it after a programmable settle interval. It also reports the write count and the checksum of the image just loaded. One instance sits beside each PicoBLAZE, between the loader core and the processor's `address`/`instruction` ports.

## Interface
Parameters:
- `BRAM_ADDRESS_WIDTH`, default 10: instruction memory depth is 2^N words of 18 bits.
- `RELEASE_CYCLES`, default 16: number of cycles `cpu_reset` stays high after loader activity ends. Legal range 1..255.

Ports:
- `clk`  in  1: single clock. The loader's `jtag_clk` is driven from this same clock net.
- `rst`  in  1: synchronous, active-high block reset.
- `jtag_rst`  in  1: loader request to hold the processor in reset.
- `jtag_en`  in  1: loader access strobe.
- `jtag_we`  in  1: loader write qualifier; valid only when `jtag_en`=1.
- `jtag_addr`  in  BRAM_ADDRESS_WIDTH: loader word address.
- `jtag_din`  in  18: loader write data.
- `jtag_dout`  out  18: loader read data, registered.
- `address`  in  BRAM_ADDRESS_WIDTH: processor fetch address.
- `bram_enable`  in  1: processor fetch enable.
- `instruction`  out  18: fetched instruction, registered.
- `cpu_reset`  out  1: reset to the PicoBLAZE.
- `load_active`  out  1: high whenever state ≠ RUN.
- `write_count`  out  BRAM_ADDRESS_WIDTH+1: number of loader writes since the current load began; saturating.
- `checksum`  out  18: sum of written words, modulo 2^18.

## Operation
- Memory is 2^AW × 18 with one physical read/write port, muxed by state. Memory contents are not affected by `rst`.
- FSM states are RUN, LOAD and SETTLE.
  - **RUN:** the processor owns the port. If `jtag_en`=1 or `jtag_rst`=1, go to LOAD next cycle. A loader access presented on that same cycle is served, and the processor fetch is dropped.
  - **LOAD:** the loader owns the port and `cpu_reset`=1. Stay in LOAD while `jtag_en` or `jtag_rst` is high. When both are low, go to SETTLE and load `settle_cnt` with RELEASE_CYCLES−1.
  - **SETTLE:** `cpu_reset`=1 and `settle_cnt` decrements each cycle. Any `jtag_en` or `jtag_rst` returns the FSM to LOAD; that access is served. When `settle_cnt`=0 and there is no loader activity, go to RUN.
- Loader access (any state in which it is served):
  - Write (`jtag_we`=1): `mem[jtag_addr]` ← `jtag_din`. The port is write-first, so `jtag_dout` ← `jtag_din` next cycle.
  - Read (`jtag_we`=0): `jtag_dout` ← `mem[jtag_addr]` next cycle.
  - With `jtag_en`=0, `jtag_dout` holds its value.
- Processor fetch: only in RUN with `bram_enable`=1 and no loader access that cycle, `instruction` ← `mem[address]` next cycle. Otherwise `instruction` holds.
- Counters:
  - The RUN→LOAD transition clears `write_count` and `checksum`. SETTLE→LOAD does not clear them.
  - Each served write increments `write_count`, saturating at 2^AW. It also adds `jtag_din` to `checksum`, wrapping modulo 2^18.
- `rst` dominates all other inputs.

## Timing
- Reset values:
  - state = SETTLE, `settle_cnt` = RELEASE_CYCLES−1, so the processor gets a clean release after power-up.
  - `cpu_reset`=1, `load_active`=1.
  - `jtag_dout`=0, `instruction`=0, `write_count`=0, `checksum`=0.
- Read latency is 1 cycle for both the loader and the processor ports.
- `cpu_reset` and `load_active` are registered and rise one cycle after the first loader activity in RUN.
- `cpu_reset` falls exactly RELEASE_CYCLES+1 cycles after the last cycle with `jtag_en`/`jtag_rst` high: one cycle to enter SETTLE, then RELEASE_CYCLES cycles of count.
- Assertion of `rst` during LOAD or SETTLE aborts the load and restarts the post-reset SETTLE sequence. Already-written words are kept.

## Configuration
- `JTAG_RESP_CHECKSUM_EN` defined: the checksum adder and register are built as described above.
- `JTAG_RESP_CHECKSUM_EN` undefined: no adder or register is built and `checksum` is tied to 18'h0. `write_count` is unaffected.

## Test plan
- Post-reset release: deassert `rst` with `jtag_en`=`jtag_rst`=0 and RELEASE_CYCLES=16 → `cpu_reset`=1 for 16 cycles after `rst` falls, then 0; `load_active` follows.
- Write/readback: write 18'h3FFFF to addr 10'h005, then read addr 10'h005 → `jtag_dout`=18'h3FFFF on the cycle after each access; `write_count`=1.
- Processor fetch: load 18'h12345 at 10'h020, wait for RUN, drive `address`=10'h020 with `bram_enable`=1 → `instruction`=18'h12345 one cycle later.
- Checksum wrap: from RUN, write 18'h20000 to two addresses → `checksum`=0 and `write_count`=2. A new load from RUN clears both to 0.
- Re-entry during SETTLE: pulse `jtag_en` when `settle_cnt`=3 → state returns to LOAD, `cpu_reset` stays 1, the full 16-cycle settle restarts, and `write_count` is not cleared.
- Reset mid-load: assert `rst` after 5 writes in LOAD → next cycle `write_count`=0 and state = SETTLE; data written before `rst` reads back intact.
